// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and constants for the decode hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int REG_AW_DEFAULT = 5;
  // Entries store rd at a fixed width so the struct can be shared; REG_AW must not exceed it.
  localparam int RD_W_MAX = 8;

  localparam int FWD_RF  = 0;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  typedef struct packed {
    logic                v;
    logic [RD_W_MAX-1:0] rd;
    logic                ld;
  } entry_t;

endpackage

// File: rtl/hazard_port_match.sv
// rtl/hazard_port_match.sv - youngest-producer search and load-use check for one decode read port.
module hazard_port_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH:1]      entries,
  input  logic [RD_W_MAX-1:0]   rs,
  input  logic                  rs_used,
  output logic [SEL_W-1:0]      sel,
  output logic                  hazard
);

  logic found;

  // Stage 1 is the youngest, so the first match in ascending order wins.
  always_comb begin
    sel    = SEL_W'(FWD_RF);
    hazard = 1'b0;
    found  = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found && entries[k].v && rs_used && (rs != '0) && (entries[k].rd == rs)) begin
        found  = 1'b1;
        sel    = SEL_W'(k);
        hazard = entries[k].ld && (k < LOAD_READY);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow pipeline of in-flight writes driving forward selects and load-use stall.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_RS     = 2,
  parameter int DEPTH      = 3,
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_RS*REG_AW-1:0]  id_rs,
  input  logic [NUM_RS-1:0]         id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_RS*SEL_W-1:0]   fwd_sel,
  output logic [31:0]               stall_cycles
);

  entry_t [DEPTH:1] entry_q;
  entry_t [DEPTH:1] entry_d;
  logic [31:0]      stall_cycles_q;
  logic [31:0]      stall_cycles_d;
  logic [NUM_RS-1:0] port_hazard;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_port
    hazard_port_match #(
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY),
      .SEL_W      (SEL_W)
    ) u_match (
      .entries (entry_q),
      .rs      (RD_W_MAX'(id_rs[i*REG_AW +: REG_AW])),
      .rs_used (id_rs_used[i]),
      .sel     (fwd_sel[i*SEL_W +: SEL_W]),
      .hazard  (port_hazard[i])
    );
  end

  assign stall        = id_valid & ~flush & (|port_hazard);
  assign stall_cycles = stall_cycles_q;

  // Older stages always advance; a flush squashes the EX entry on its way to stage 2.
  always_comb begin
    entry_d       = entry_q;
    entry_d[1].v  = id_valid & id_regwrite & (id_rd != '0) & ~flush & ~stall;
    entry_d[1].rd = RD_W_MAX'(id_rd);
    entry_d[1].ld = id_is_load;
    for (int k = 2; k <= DEPTH; k++) begin
      entry_d[k] = entry_q[k-1];
      if (k == 2 && flush) begin
        entry_d[k].v = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      entry_q        <= entry_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic        flush;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .stall_cycles (stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [1:0] used, input logic [4:0] rd, input logic rw,
                     input logic ld, input logic fl);
    id_valid    = v;
    id_rs       = {r1, r0};
    id_rs_used  = used;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    flush       = fl;
  endtask

  task automatic idle(input int n);
    dec(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  // lw x7 followed by a dependent add: one stall cycle each time.
  task automatic load_use_pair(input string tag);
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq({tag, "_stall"}, 32'(stall), 32'd1);
    tick();
    dec(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dec(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_fwd", 32'(fwd_sel), 32'd0);
    check_eq("rst_cnt", stall_cycles, 32'd0);

    // 1: back-to-back dependency forwards from EX
    tick();
    dec(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("t1_nodep_fwd", 32'(fwd_sel), 32'd0);
    tick();
    dec(1'b1, 5'd5, 5'd6, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("t1_sel0", 32'(fwd_sel[1:0]), 32'd1);
    check_eq("t1_stall", 32'(stall), 32'd0);
    tick();
    idle(3);

    // 2: youngest producer wins; then a producer ageing through MEM and WB
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("t2_youngest_sel1", 32'(fwd_sel[3:2]), 32'd1);
    check_eq("t2_sel0_unused", 32'(fwd_sel[1:0]), 32'd0);
    tick();
    idle(3);
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    idle(1);
    dec(1'b1, 5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("t2_gap_sel_mem", 32'(fwd_sel[3:2]), 32'd2);
    tick();
    check_eq("t2_gap_sel_wb", 32'(fwd_sel[3:2]), 32'd3);
    tick();
    check_eq("t2_gap_sel_rf", 32'(fwd_sel[3:2]), 32'd0);
    tick();
    idle(3);

    // 3: load-use stalls exactly one cycle
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd7, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("t3_stall", 32'(stall), 32'd1);
    check_eq("t3_sel0_stalled", 32'(fwd_sel[1:0]), 32'd1);
    tick();
    check_eq("t3_stall_released", 32'(stall), 32'd0);
    check_eq("t3_sel0_mem", 32'(fwd_sel[1:0]), 32'd2);
    check_eq("t3_cnt", stall_cycles, 32'd1);
    tick();
    idle(3);
    check_eq("t3_cnt_hold", stall_cycles, 32'd1);

    // 4: x0 never forwards or stalls
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("t4_x0_fwd", 32'(fwd_sel), 32'd0);
    check_eq("t4_x0_stall", 32'(stall), 32'd0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("t4_lwx0_fwd", 32'(fwd_sel), 32'd0);
    check_eq("t4_lwx0_stall", 32'(stall), 32'd0);
    tick();
    idle(3);

    // 5: flush beats a hazard and squashes the EX entry
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd7, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("t5_flush_stall", 32'(stall), 32'd0);
    check_eq("t5_flush_sel0", 32'(fwd_sel[1:0]), 32'd1);
    tick();
    dec(1'b1, 5'd7, 5'd10, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("t5_squashed_fwd", 32'(fwd_sel), 32'd0);
    check_eq("t5_after_stall", 32'(stall), 32'd0);
    check_eq("t5_cnt", stall_cycles, 32'd1);
    tick();
    idle(3);
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    idle(1);
    dec(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("t5_flush_mem_sel", 32'(fwd_sel[1:0]), 32'd2);
    check_eq("t5_flush_mem_stall", 32'(stall), 32'd0);
    tick();
    dec(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("t5_mem_advances", 32'(fwd_sel[1:0]), 32'd3);
    tick();
    idle(3);

    // 6: reset mid-flight, then counter saturation
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd11, 5'd13, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("t6_pre_sel0", 32'(fwd_sel[1:0]), 32'd3);
    check_eq("t6_pre_sel1", 32'(fwd_sel[3:2]), 32'd1);
    check_eq("t6_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("t6_rst_fwd", 32'(fwd_sel), 32'd0);
    check_eq("t6_rst_stall", 32'(stall), 32'd0);
    check_eq("t6_rst_cnt", stall_cycles, 32'd0);
    idle(1);
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles_q;
    #1;
    check_eq("t6_cnt_preset", stall_cycles, 32'hFFFF_FFFD);
    tick();
    load_use_pair("sat1");
    check_eq("t6_cnt_fe", stall_cycles, 32'hFFFF_FFFE);
    load_use_pair("sat2");
    check_eq("t6_cnt_ff", stall_cycles, 32'hFFFF_FFFF);
    load_use_pair("sat3");
    check_eq("t6_cnt_sat", stall_cycles, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
